// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent read/write engines.
// AW and W may arrive in either order; writes honour byte strobes, out-of-range accesses get SLVERR.
module axi4_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < STRB_W; i++)
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wstate_t               wstate;
  rstate_t               rstate;
  logic                  awready, wready, bvalid, arready, rvalid;
  logic [1:0]            bresp, rresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic [IDX_W-1:0]      aw_idx, ar_idx, commit_idx;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;
  logic                  aw_hs, w_hs, ar_hs, commit_en, commit_ok;
  logic                  unused_addr_lsbs;

  assign aw_idx = S_AWADDR[ADDR_WIDTH-1:LSB];
  assign ar_idx = S_ARADDR[ADDR_WIDTH-1:LSB];
  assign unused_addr_lsbs = ^{S_AWADDR[LSB-1:0], S_ARADDR[LSB-1:0]};

  assign aw_hs = S_AWVALID & awready;
  assign w_hs  = S_WVALID & wready;
  assign ar_hs = S_ARVALID & arready;

  // Commit source: live channel for whichever half arrives last, captured copy for the other.
  always_comb begin
    commit_en   = 1'b0;
    commit_idx  = aw_idx;
    commit_data = S_WDATA;
    commit_strb = S_WSTRB;
    case (wstate)
      W_IDLE:   commit_en = aw_hs & w_hs;
      W_HAVE_A: begin
        commit_en  = w_hs;
        commit_idx = aw_idx_q;
      end
      W_HAVE_W: begin
        commit_en   = aw_hs;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
      end
      default: commit_en = 1'b0;
    endcase
    commit_ok = in_range(commit_idx);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_en && commit_ok) begin
      regs[commit_idx[REG_AW-1:0]] <= merge_bytes(regs[commit_idx[REG_AW-1:0]], commit_data, commit_strb);
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_idx_q <= aw_idx;
    if (w_hs) begin
      wdata_q <= S_WDATA;
      wstrb_q <= S_WSTRB;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wstate  <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else if (commit_en) begin
      wstate  <= W_RESP;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            wstate  <= W_HAVE_A;
            awready <= 1'b0;
            wready  <= 1'b1;
          end else if (w_hs) begin
            wstate  <= W_HAVE_W;
            awready <= 1'b1;
            wready  <= 1'b0;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            wstate  <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read engine samples the array before any same-edge commit lands.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            rstate  <= R_DATA;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= in_range(ar_idx) ? regs[ar_idx[REG_AW-1:0]] : '0;
            rresp   <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_RREADY) begin
            rstate  <= R_IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AWREADY = awready;
  assign S_WREADY  = wready;
  assign S_BVALID  = bvalid;
  assign S_BRESP   = bresp;
  assign S_ARREADY = arready;
  assign S_RVALID  = rvalid;
  assign S_RDATA   = rdata;
  assign S_RRESP   = rresp;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: table of single transactions plus hand-built corner sequences.
module tb_axi4_lite_regfile;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [31:0] S_ARADDR = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4_lite_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Raise the selected valids and drop each one after its handshake edge.
  task automatic do_hs(input logic do_aw, input logic do_w);
    logic aw_f, w_f;
    if (do_aw) S_AWVALID = 1'b1;
    if (do_w)  S_WVALID  = 1'b1;
    for (int c = 0; c < 50 && (S_AWVALID || S_WVALID); c++) begin
      aw_f = S_AWVALID && S_AWREADY;
      w_f  = S_WVALID && S_WREADY;
      tick();
      if (aw_f) S_AWVALID = 1'b0;
      if (w_f)  S_WVALID  = 1'b0;
    end
    check("aw_w_handshake_done", {S_AWVALID, S_WVALID}, 2'b00);
    S_AWVALID = 1'b0;
    S_WVALID  = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    for (int c = 0; c < 50 && !S_BVALID; c++) tick();
    check("bvalid_seen", S_BVALID, 1'b1);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    tick();
    S_BREADY = 1'b0;
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int order, output logic [1:0] resp);
    S_AWADDR = addr;
    S_WDATA  = data;
    S_WSTRB  = strb;
    if (order == 1) begin
      do_hs(1'b1, 1'b0);
      do_hs(1'b0, 1'b1);
    end else if (order == 2) begin
      do_hs(1'b0, 1'b1);
      do_hs(1'b1, 1'b0);
    end else begin
      do_hs(1'b1, 1'b1);
    end
    get_b(resp);
  endtask

  task automatic send_ar(input logic [31:0] addr);
    S_ARADDR  = addr;
    S_ARVALID = 1'b1;
    for (int c = 0; c < 50 && !S_ARREADY; c++) tick();
    tick();
    S_ARVALID = 1'b0;
  endtask

  task automatic get_r(output logic [31:0] data, output logic [1:0] resp);
    for (int c = 0; c < 50 && !S_RVALID; c++) tick();
    check("rvalid_seen", S_RVALID, 1'b1);
    data = S_RDATA;
    resp = S_RRESP;
    S_RREADY = 1'b1;
    tick();
    S_RREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    send_ar(addr);
    get_r(data, resp);
  endtask

  typedef struct {
    bit          wr;
    int          order;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;

    vecs[0]  = '{0, 0, 32'h0000_0014, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    vecs[1]  = '{1, 1, 32'h0000_0008, 32'hDEADBEEF,  4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1, 2, 32'h0000_0008, 32'h0000_00AA, 4'h1, 2'b00, 32'h0};
    vecs[3]  = '{0, 0, 32'h0000_0008, 32'h0,         4'h0, 2'b00, 32'hDEADBEAA};
    vecs[4]  = '{1, 0, 32'h0000_007C, 32'hCAFEF00D,  4'hF, 2'b00, 32'h0};
    vecs[5]  = '{1, 0, 32'h0000_0080, 32'h12345678,  4'hF, 2'b10, 32'h0};
    vecs[6]  = '{0, 0, 32'h0000_0080, 32'h0,         4'h0, 2'b10, 32'h0000_0000};
    vecs[7]  = '{0, 0, 32'h0000_007C, 32'h0,         4'h0, 2'b00, 32'hCAFEF00D};
    vecs[8]  = '{1, 0, 32'h0000_000C, 32'h11223344,  4'hA, 2'b00, 32'h0};
    vecs[9]  = '{0, 0, 32'h0000_000E, 32'h0,         4'h0, 2'b00, 32'h11003300};
    vecs[10] = '{1, 2, 32'h0000_0010, 32'hFFFFFFFF,  4'h0, 2'b00, 32'h0};
    vecs[11] = '{0, 0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'h0000_0000};
    vecs[12] = '{1, 1, 32'hFFFF_FFFC, 32'h55AA55AA,  4'hF, 2'b10, 32'h0};
    vecs[13] = '{0, 0, 32'hFFFF_FFF0, 32'h0,         4'h0, 2'b10, 32'h0000_0000};

    // Reset held for three edges, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs_zero",
            {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, S_RDATA, S_RRESP, S_BRESP},
            '0);
    end
    ARESETN = 1'b1;
    tick();
    check("readys_after_release", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].order, br);
        check($sformatf("vec%0d_bresp", i), br, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, rd, rr);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_resp);
      end
    end

    // Read overtakes a write parked in W_HAVE_A
    axi_write(32'h04, 32'h01010101, 4'hF, 0, br);
    S_AWADDR = 32'h04;
    S_WDATA  = 32'hA5A5A5A5;
    S_WSTRB  = 4'hF;
    do_hs(1'b1, 1'b0);
    check("have_a_awready_low", {S_AWREADY, S_WREADY}, 2'b01);
    axi_read(32'h04, rd, rr);
    check("concurrent_read_old", rd, 32'h01010101);
    check("concurrent_read_resp", rr, 2'b00);
    do_hs(1'b0, 1'b1);
    get_b(br);
    check("concurrent_write_resp", br, 2'b00);
    axi_read(32'h04, rd, rr);
    check("concurrent_read_new", rd, 32'hA5A5A5A5);

    // AR handshake on the same edge as the commit to the same register
    S_AWADDR = 32'h18;
    S_WDATA  = 32'h77777777;
    do_hs(1'b1, 1'b0);
    S_ARADDR  = 32'h18;
    S_ARVALID = 1'b1;
    S_WVALID  = 1'b1;
    tick();
    S_ARVALID = 1'b0;
    S_WVALID  = 1'b0;
    check("collision_both_valid", {S_RVALID, S_BVALID}, 2'b11);
    check("collision_read_old", S_RDATA, 32'h0);
    get_r(rd, rr);
    get_b(br);
    axi_read(32'h18, rd, rr);
    check("collision_read_after", rd, 32'h77777777);

    // Read back-pressure
    send_ar(32'h08);
    for (int i = 0; i < 5; i++) begin
      check("r_stall", {S_RVALID, S_ARREADY, S_RDATA, S_RRESP}, {1'b1, 1'b0, 32'hDEADBEAA, 2'b00});
      tick();
    end
    S_RREADY = 1'b1;
    tick();
    S_RREADY = 1'b0;
    check("r_release", {S_RVALID, S_ARREADY}, 2'b01);

    // Write back-pressure
    S_AWADDR = 32'h20;
    S_WDATA  = 32'h0BADF00D;
    S_WSTRB  = 4'hF;
    do_hs(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("b_stall", {S_BVALID, S_AWREADY, S_WREADY, S_BRESP}, {3'b100, 2'b00});
      tick();
    end
    S_BREADY = 1'b1;
    tick();
    S_BREADY = 1'b0;
    check("b_release", {S_BVALID, S_AWREADY, S_WREADY}, 3'b011);

    // Reset while a write holds only its address
    S_AWADDR = 32'h24;
    S_WDATA  = 32'h99999999;
    do_hs(1'b1, 1'b0);
    ARESETN = 1'b0;
    tick();
    check("midreset_outputs", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID}, 4'b0000);
    ARESETN = 1'b1;
    tick();
    check("midreset_no_b", {S_BVALID, S_AWREADY, S_WREADY}, 3'b011);
    tick();
    check("midreset_no_b_later", S_BVALID, 1'b0);
    axi_read(32'h24, rd, rr);
    check("midreset_target_zero", rd, 32'h0);
    axi_read(32'h08, rd, rr);
    check("midreset_regs_cleared", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
